alu_md: RTL

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_pkg.sv | 22 ++
 rtl/alu_md_if.sv | 16 +
 rtl/md_step.sv | 19 +
 rtl/alu_md.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared decoder types and op-class helpers for the ALU and multiply/divide unit
package alu_md_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} md_state_t;
  function automatic logic is_div(md_op_t op);
    return op[2];
  endfunction
  function automatic logic is_rem(md_op_t op);
    return op[2] & op[1];
  endfunction
  function automatic logic sgn_a(md_op_t op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction
  function automatic logic sgn_b(md_op_t op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction
endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: request/response handshake bundle of the multiply/divide unit
interface alu_md_if import alu_md_pkg::*; #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  md_op_t          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  modport master (output in_valid, op, a, b, flush, out_ready, input in_ready, out_valid, res);
  modport slave (input in_valid, op, a, b, flush, out_ready, output in_ready, out_valid, res);
endinterface

// File: rtl/md_step.sv
// md_step: one radix-2 iteration, shift-add multiply or restoring divide on a 2*XLEN accumulator
module md_step #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  // multiply: acc = {partial, multiplier}; add multiplicand when lsb set, then shift right
  assign sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  // divide: acc = {remainder, dividend}; trial-subtract on the left-shifted remainder
  assign diff = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};
  assign acc_o = div_i ? (diff[XLEN] ? {acc_i[2*XLEN-2:0], 1'b0}
                                     : {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1})
                       : {sum, acc_i[XLEN-1:1]};
endmodule

// File: rtl/alu_md.sv
// alu_md: iterative multiply/divide unit with sign fixup, early-out cases and valid/ready handshake
module alu_md import alu_md_pkg::*; #(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input logic     clk,
  input logic     reset_n,
  alu_md_if.slave md
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  md_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  md_op_t            op_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] acc_q, step_acc, prod;
  logic [XLEN-1:0]   opnd_q, abs_a, abs_b, sp_res, quo, rem, fix_res;
  logic              accept, sa, sb, div0, ovf, zmul, special;
  assign accept  = md.in_valid && state_q == IDLE && !md.flush;
  assign sa      = sgn_a(md.op) && md.a[XLEN-1];
  assign sb      = sgn_b(md.op) && md.b[XLEN-1];
  assign abs_a   = sa ? -md.a : md.a;
  assign abs_b   = sb ? -md.b : md.b;
  assign div0    = is_div(md.op) && md.b == '0;
  assign ovf     = is_div(md.op) && sgn_b(md.op) && md.a == MIN_NEG && md.b == '1;
  assign zmul    = FAST_ZERO && !is_div(md.op) && (md.a == '0 || md.b == '0);
  assign special = div0 || ovf || zmul;
  assign sp_res  = div0 ? (is_rem(md.op) ? md.a : '1) : ovf ? (is_rem(md.op) ? '0 : md.a) : '0;
  assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo     = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem     = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res = is_div(op_q) ? (is_rem(op_q) ? rem : quo)
                                : (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  md_step #(.XLEN(XLEN)) u_step (
    .div_i (is_div(op_q)),
    .acc_i (acc_q),
    .opnd_i(opnd_q),
    .acc_o (step_acc)
  );
  // next state: accept/early-out in IDLE, XLEN steps in CALC, result select in FIXUP, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = special ? DONE : CALC;
        res_d   = special ? sp_res : res_q;
      end
      CALC: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(XLEN - 1) ? FIXUP : CALC;
      end
      FIXUP: begin
        state_d = DONE;
        res_d   = fix_res;
      end
      DONE: state_d = md.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (md.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  // control state with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  // operand capture on accept and accumulator iteration, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= md.op;
      sa_q   <= sa;
      sb_q   <= sb;
      acc_q  <= {{XLEN{1'b0}}, is_div(md.op) ? abs_a : abs_b};
      opnd_q <= is_div(md.op) ? abs_b : abs_a;
    end else if (state_q == CALC) begin
      acc_q <= step_acc;
    end
  end
  assign md.in_ready  = state_q == IDLE;
  assign md.out_valid = state_q == DONE;
  assign md.res       = res_q;
endmodule
